rx_udp: RTL and testbench

Receive-side UDP stage directly downstream of the IPv4 parser, clocked on `RX_CLK`. It consumes the IPv4 payload byte stream, which is qualified by `rx_data_udp`. It parses the 8-byte UDP header, filters on destination port, and emits the UDP payload as a registered byte stream with a last-byte marker. It also flags frames that are truncated or malformed.

---
 rtl/eth_pkg.sv | 16 +
 rtl/rx_udp.sv | 118 +++++++++++
 tb/tb_rx_udp.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/IPv4/UDP receive-path constants and UDP parser state encodings
package eth_pkg;
  localparam int UDP_HDR_LEN = 8;
  localparam logic [7:0] PROTO_UDP = 8'h11;
  typedef enum logic [2:0] {
    S_SRC,
    S_DST,
    S_LEN,
    S_CSUM,
    S_PAY,
    S_DROP
  } udp_state_t;
  function automatic logic is_hdr(input udp_state_t s);
    return (s == S_SRC) || (s == S_DST) || (s == S_LEN) || (s == S_CSUM);
  endfunction
endpackage

// File: rtl/rx_udp.sv
// rx_udp: UDP header parser, destination-port filter and registered payload streamer
module rx_udp
  import eth_pkg::*;
#(
  parameter int OCT     = 8,
  parameter int HDR_LEN = UDP_HDR_LEN
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [15:0]    udp_port,
  input  logic           rx_data_udp,
  input  logic [OCT-1:0] rx_data,
  output logic [15:0]    rx_src_port,
  output logic [15:0]    rx_dst_port,
  output logic [15:0]    rx_udp_len,
  output logic           rx_udp_valid,
  output logic [OCT-1:0] rx_udp_data,
  output logic           rx_udp_last,
  output logic           rx_udp_err
);
  udp_state_t     r_state, w_state;
  logic           r_idx, w_idx;
  logic [15:0]    r_remain, w_remain;
  logic [15:0]    r_csum, w_csum;
  logic [15:0]    w_src, w_dst, w_len;
  logic           w_valid, w_last, w_err;
  logic [OCT-1:0] w_data;
  logic [15:0]    w_len_full;
  logic           w_short, w_port_miss, w_fall_err;
  // header fields shift in MSB-first, one byte per qualified cycle
  assign w_len_full  = 16'({rx_udp_len, rx_data});
  assign w_short     = w_len_full < 16'(HDR_LEN);
  assign w_port_miss = (udp_port != 16'h0000) && (rx_dst_port != udp_port);
  assign w_fall_err  = (r_state == S_PAY) || (is_hdr(r_state) && (r_state != S_SRC || r_idx));
  // next-state, header capture and strobe generation
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_remain = r_remain;
    w_csum   = r_csum;
    w_src    = rx_src_port;
    w_dst    = rx_dst_port;
    w_len    = rx_udp_len;
    w_data   = rx_udp_data;
    w_valid  = 1'b0;
    w_last   = 1'b0;
    w_err    = 1'b0;
    if (!rx_data_udp) begin
      w_state = S_SRC;
      w_idx   = 1'b0;
      w_err   = w_fall_err;
    end else begin
      case (r_state)
        S_SRC: begin
          w_src   = 16'({rx_src_port, rx_data});
          w_idx   = ~r_idx;
          w_state = r_idx ? S_DST : S_SRC;
        end
        S_DST: begin
          w_dst   = 16'({rx_dst_port, rx_data});
          w_idx   = ~r_idx;
          w_state = r_idx ? S_LEN : S_DST;
        end
        S_LEN: begin
          w_len = w_len_full;
          w_idx = ~r_idx;
          if (r_idx) begin
            w_state  = w_short ? S_DROP : S_CSUM;
            w_err    = w_short;
            w_remain = w_short ? r_remain : w_len_full - 16'(HDR_LEN);
          end
        end
        S_CSUM: begin
          w_csum = (r_csum << OCT) | 16'(rx_data);
          w_idx  = ~r_idx;
          if (r_idx)
            w_state = (w_port_miss || r_remain == 16'd0) ? S_DROP : S_PAY;
        end
        S_PAY: begin
          w_valid  = 1'b1;
          w_data   = rx_data;
          w_remain = r_remain - 16'd1;
          w_last   = r_remain == 16'd1;
          w_state  = (r_remain == 16'd1) ? S_DROP : S_PAY;
        end
        default: ;
      endcase
    end
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      r_state      <= S_SRC;
      r_idx        <= 1'b0;
      r_remain     <= '0;
      r_csum       <= '0;
      rx_src_port  <= '0;
      rx_dst_port  <= '0;
      rx_udp_len   <= '0;
      rx_udp_valid <= 1'b0;
      rx_udp_data  <= '0;
      rx_udp_last  <= 1'b0;
      rx_udp_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_remain     <= w_remain;
      r_csum       <= w_csum;
      rx_src_port  <= w_src;
      rx_dst_port  <= w_dst;
      rx_udp_len   <= w_len;
      rx_udp_valid <= w_valid;
      rx_udp_data  <= w_data;
      rx_udp_last  <= w_last;
      rx_udp_err   <= w_err;
    end
  end
endmodule

// File: tb/tb_rx_udp.sv
// tb_rx_udp: frame-level reference model with per-cycle compare plus directed literal checks
module tb_rx_udp;
  localparam int N = 40000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] udp_port = 16'h0000;
  logic        rx_data_udp = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] rx_src_port, rx_dst_port, rx_udp_len;
  logic        rx_udp_valid, rx_udp_last, rx_udp_err;
  logic [7:0]  rx_udp_data;
  int          cyc = 0, checks = 0, errors = 0, got_err = 0;
  bit          ev_v[N], ev_l[N], ev_e[N], hc[N];
  bit [7:0]    ev_d[N];
  bit [15:0]   ex_src[N], ex_dst[N], ex_len[N];
  logic [8:0]  got_q[$];
  rx_udp dut (
    .RX_CLK(clk), .rst(rst), .udp_port(udp_port), .rx_data_udp(rx_data_udp), .rx_data(rx_data),
    .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port), .rx_udp_len(rx_udp_len),
    .rx_udp_valid(rx_udp_valid), .rx_udp_data(rx_udp_data), .rx_udp_last(rx_udp_last),
    .rx_udp_err(rx_udp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_zero();
    chk("rst_src", 32'(rx_src_port), 0);
    chk("rst_dst", 32'(rx_dst_port), 0);
    chk("rst_len", 32'(rx_udp_len), 0);
    chk("rst_valid", 32'(rx_udp_valid), 0);
    chk("rst_data", 32'(rx_udp_data), 0);
    chk("rst_last", 32'(rx_udp_last), 0);
    chk("rst_err", 32'(rx_udp_err), 0);
  endtask
  // per-cycle compare against the model's expectation tables
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (cyc < N) begin
      chk("valid", 32'(rx_udp_valid), 32'(ev_v[cyc]));
      chk("last", 32'(rx_udp_last), 32'(ev_l[cyc]));
      chk("err", 32'(rx_udp_err), 32'(ev_e[cyc]));
      if (ev_v[cyc]) chk("data", 32'(rx_udp_data), 32'(ev_d[cyc]));
      if (hc[cyc]) begin
        chk("src_port", 32'(rx_src_port), 32'(ex_src[cyc]));
        chk("dst_port", 32'(rx_dst_port), 32'(ex_dst[cyc]));
        chk("udp_len", 32'(rx_udp_len), 32'(ex_len[cyc]));
      end
    end
    if (rx_udp_valid) got_q.push_back({rx_udp_last, rx_udp_data});
    if (rx_udp_err) got_err++;
  end
  task automatic set_hdr(input int e, input logic [7:0] b[$]);
    hc[e] = 1'b1;
    ex_src[e] = {b[0], b[1]};
    ex_dst[e] = {b[2], b[3]};
    ex_len[e] = {b[4], b[5]};
  endtask
  // drive one frame of n bytes and record what the outputs must be after each edge
  task automatic run_frame(input logic [7:0] b[$], input int n, input int gap, input int chg_at,
                           input logic [15:0] new_port, input bit abort);
    int  L;
    int  e;
    bit  pass;
    L = -1;
    pass = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_data_udp = 1'b1;
      rx_data = b[k];
      e = cyc + 1;
      if (k == chg_at) udp_port = new_port;
      if (k >= 5) L = int'({b[4], b[5]});
      if (k == 5 && L < 8) ev_e[e] = 1'b1;
      if (k == 7) pass = (udp_port == 16'h0000) || ({b[2], b[3]} == udp_port);
      if (k >= 8 && L >= 8 && pass && k < L) begin
        ev_v[e] = 1'b1;
        ev_d[e] = b[k];
        ev_l[e] = (k == L - 1);
      end
      if (k >= 8) set_hdr(e, b);
    end
    if (abort) begin
      @(negedge clk);
      #1 rst = 1'b1;
      rx_data_udp = 1'b0;
      #1 chk_zero();
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_data_udp = 1'b0;
      rx_data = 8'($urandom);
      e = cyc + 1;
      if (g == 0)
        ev_e[e] = (n < 8 && !(n >= 6 && L < 8)) || (n >= 8 && L >= 8 && pass && n < L);
      if (n >= 8) set_hdr(e, b);
    end
  endtask
  task automatic settle();
    repeat (2) @(posedge clk);
    #2;
  endtask
  initial begin
    logic [7:0] f1[$], f3[$], f4[$], f5[$];
    f1 = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    f3 = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h09, 8'h00, 8'h00, 8'hAA};
    repeat (17) f3.push_back(8'($urandom));
    f4 = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h06, 8'h00, 8'h00, 8'h01, 8'h02};
    f5 = '{8'hAB, 8'hCD, 8'h00, 8'h50, 8'h00, 8'h10, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    repeat (2) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    udp_port = 16'h0050;
    got_q = {}; got_err = 0;
    run_frame(f1, 12, 2, -1, 0, 0);
    settle();
    chk("f1_beats", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      chk("f1_b0", 32'(got_q[0]), 32'h0DE);
      chk("f1_b1", 32'(got_q[1]), 32'h0AD);
      chk("f1_b2", 32'(got_q[2]), 32'h0BE);
      chk("f1_b3", 32'(got_q[3]), 32'h1EF);
    end
    chk("f1_err", 32'(got_err), 0);
    chk("f1_src", 32'(rx_src_port), 32'h1234);
    chk("f1_dst", 32'(rx_dst_port), 32'h0050);
    chk("f1_len", 32'(rx_udp_len), 32'h000C);
    udp_port = 16'h0051;
    got_q = {}; got_err = 0;
    run_frame(f1, 12, 2, -1, 0, 0);
    settle();
    chk("f2_beats", 32'(got_q.size()), 0);
    chk("f2_err", 32'(got_err), 0);
    chk("f2_dst", 32'(rx_dst_port), 32'h0050);
    udp_port = 16'h0050;
    got_q = {}; got_err = 0;
    run_frame(f3, 26, 1, -1, 0, 0);
    settle();
    chk("f3_beats", 32'(got_q.size()), 1);
    if (got_q.size() == 1) chk("f3_b0", 32'(got_q[0]), 32'h1AA);
    chk("f3_err", 32'(got_err), 0);
    got_q = {}; got_err = 0;
    run_frame(f4, 10, 1, -1, 0, 0);
    settle();
    chk("f4_beats", 32'(got_q.size()), 0);
    chk("f4_err", 32'(got_err), 1);
    got_q = {}; got_err = 0;
    run_frame(f5, 11, 1, -1, 0, 0);
    settle();
    chk("f5_beats", 32'(got_q.size()), 3);
    if (got_q.size() == 3) chk("f5_b2", 32'(got_q[2]), 32'h033);
    chk("f5_err", 32'(got_err), 1);
    got_q = {}; got_err = 0;
    run_frame(f1, 12, 1, -1, 0, 0);
    settle();
    chk("f6_beats", 32'(got_q.size()), 4);
    if (got_q.size() == 4) chk("f6_b3", 32'(got_q[3]), 32'h1EF);
    got_q = {}; got_err = 0;
    run_frame(f1, 10, 1, -1, 0, 1);
    settle();
    chk("rst_beats", 32'(got_q.size()), 2);
    chk("rst_noerr", 32'(got_err), 0);
    got_q = {}; got_err = 0;
    run_frame(f1, 12, 1, -1, 0, 0);
    settle();
    chk("post_rst_beats", 32'(got_q.size()), 4);
    chk("post_rst_src", 32'(rx_src_port), 32'h1234);
    for (int t = 0; t < 250; t++) begin
      logic [7:0]  q[$];
      logic [15:0] dp;
      int          L, n, m, chg;
      case ($urandom_range(0, 2))
        0: udp_port = 16'h0000;
        1: udp_port = 16'h0050;
        default: udp_port = 16'($urandom);
      endcase
      L = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 24));
      m = (L > 8) ? L : 8;
      n = int'($urandom_range(1, m + 4));
      q = {};
      for (int i = 0; i < ((n > 8) ? n : 8); i++) q.push_back(8'($urandom));
      dp = $urandom_range(0, 1) ? ((udp_port == 16'h0000) ? 16'h0050 : udp_port) : 16'($urandom);
      q[2] = dp[15:8];
      q[3] = dp[7:0];
      q[4] = 8'(L >> 8);
      q[5] = 8'(L);
      chg = (n > 9 && $urandom_range(0, 3) == 0) ? int'($urandom_range(8, n - 1)) : -1;
      run_frame(q, n, int'($urandom_range(1, 3)), chg, 16'($urandom), 1'b0);
    end
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
